// File: rtl/handshake_pkg.sv
// Shared constants and buffer occupancy encoding for the constant-source /
// constant-check handshake family.
package handshake_pkg;

  localparam logic [16:0] CONST_165 = 17'b11111000011000011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/handshake_buffer_2.sv
// Two-entry elastic buffer. ins_ready depends only on registered occupancy and
// outs/outs_valid come straight from registers, so neither side sees a comb path.
module handshake_buffer_2
  import handshake_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ins,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic [WIDTH-1:0] outs,
  output logic             outs_valid,
  input  logic             outs_ready
);

  occ_t             occ, occ_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic [WIDTH-1:0] tail, tail_nxt;
  logic             push, pop;

  // Held low during reset so no handshake can be reported in the reset cycle.
  assign ins_ready  = rst && (occ != FULL);
  assign outs_valid = (occ != EMPTY);
  assign outs       = head;
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ  <= EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      occ  <= occ_nxt;
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    case (occ)
      EMPTY: begin
        if (push) begin
          head_nxt = ins;
          occ_nxt  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = ins;
        end else if (push) begin
          tail_nxt = ins;
          occ_nxt  = FULL;
        end else if (pop) begin
          occ_nxt  = EMPTY;
        end
      end
      FULL: begin
        // push cannot happen here since ins_ready is low
        if (pop) begin
          head_nxt = tail;
          occ_nxt  = ONE;
        end
      end
      default: occ_nxt = EMPTY;
    endcase
  end

endmodule

// File: rtl/handshake_constant_check_165.sv
// Sink-side checker: compares each accepted token with CONST_VALUE, emits a
// 1-bit match token through a 2-entry buffer and keeps saturating statistics.
module handshake_constant_check_165
  import handshake_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(CONST_165),
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count
);

  logic eq, accept;

  assign eq     = (ins == CONST_VALUE);
  assign accept = ins_valid && ins_ready;

  handshake_buffer_2 #(.WIDTH(1)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .ins        (eq),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      match_count    <= '0;
      mismatch_count <= '0;
    end else if (accept) begin
      if (eq) begin
        if (match_count != '1) match_count <= match_count + 1'b1;
      end else begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_handshake_constant_check_165.sv
// Scoreboard bench: accepted tokens push their expected match bit; a monitor
// pops on every output handshake and also checks flags and counters each cycle.
module tb_handshake_constant_check_165;

  localparam int          DW   = 32;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] K    = 32'h0001_F0C3;

  logic          clk = 0;
  logic          rst = 0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 0;
  logic          ins_ready;
  logic          outs;
  logic          outs_valid;
  logic          outs_ready = 0;
  logic [CW-1:0] match_count, mismatch_count;

  int cmps = 0;
  int errs = 0;

  bit q[$];
  int m_match = 0, m_mis = 0;

  handshake_constant_check_165 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ins            (ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .outs           (outs),
    .outs_valid     (outs_valid),
    .outs_ready     (outs_ready),
    .match_count    (match_count),
    .mismatch_count (mismatch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    cmps++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: everything sampled at the falling edge.
  initial begin : monitor
    bit hold = 0;
    bit held_val = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("outs_valid", int'(outs_valid), int'(q.size() > 0));
      check("ins_ready", int'(ins_ready), int'(rst && q.size() < 2));
      check("match_count", int'(match_count), m_match);
      check("mismatch_count", int'(mismatch_count), m_mis);
      if (hold) begin
        check("hold_valid", int'(outs_valid), 1);
        check("hold_outs", int'(outs), int'(held_val));
      end
      hold = 0;
      if (!rst) begin
        q.delete();
        m_match = 0;
        m_mis = 0;
      end else begin
        if (outs_valid && outs_ready && q.size() > 0) begin
          bit e;
          e = q.pop_front();
          check("outs_data", int'(outs), int'(e));
        end else if (outs_valid && !outs_ready) begin
          hold = 1;
          held_val = outs;
        end
        if (ins_valid && ins_ready) begin
          bit e;
          e = (ins == K);
          q.push_back(e);
          if (e) m_match = (m_match < CMAX) ? m_match + 1 : CMAX;
          else   m_mis   = (m_mis   < CMAX) ? m_mis   + 1 : CMAX;
        end
      end
    end
  end

  // Offer one token and wait (bounded) until it is accepted.
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    bit acc = 0;
    ins_valid = 1;
    ins = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = ins_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      cmps++;
      errs++;
      $display("FAIL send_timeout at %0t: got accepted=0 expected accepted=1", $time);
    end
    ins_valid = 0;
    ins = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    logic [DW-1:0] bp [4];
    int idx;
    int acc_cnt;
    bp[0] = K; bp[1] = '0; bp[2] = K; bp[3] = '0;

    // Reset held for 3 cycles, then release.
    rst = 0;
    idle(3);
    check("rst_ins_ready", int'(ins_ready), 0);
    check("rst_outs_valid", int'(outs_valid), 0);
    rst = 1;
    idle(1);
    check("post_rst_ready", int'(ins_ready), 1);

    // Streaming at full rate.
    outs_ready = 1;
    send(K);
    send(K ^ 32'h1);
    send(K);
    idle(2);
    check("stream_match", int'(match_count), 2);
    check("stream_mismatch", int'(mismatch_count), 1);

    // Backpressure: offer 4 tokens with outs_ready low, expect 2 absorbed.
    outs_ready = 0;
    idx = 0;
    acc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      ins_valid = 1;
      ins = bp[idx];
      @(negedge clk);
      if (ins_ready) begin
        acc_cnt++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc_cnt, 2);
    outs_ready = 1;
    while (idx < 4) begin
      send(bp[idx]);
      idx++;
    end
    idle(4);

    // Saturation of both counters.
    rst = 0;
    idle(1);
    rst = 1;
    for (int i = 0; i < 20; i++) send(K + 32'(i + 1));
    idle(2);
    check("sat_mismatch", int'(mismatch_count), 15);
    check("sat_match", int'(match_count), 0);
    for (int i = 0; i < 20; i++) send(K);
    idle(2);
    check("sat_match2", int'(match_count), 15);

    // Reset while FULL: tokens discarded.
    outs_ready = 0;
    send(K);
    send(K);
    idle(1);
    rst = 0;
    idle(1);
    rst = 1;
    outs_ready = 1;
    idle(3);
    check("full_rst_valid", int'(outs_valid), 0);
    check("full_rst_cnt", int'(match_count), 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      int sel;
      sel = $urandom_range(0, 3);
      ins_valid = ($urandom_range(0, 3) != 0);
      case (sel)
        0, 1: ins = K;
        2:    ins = K ^ (32'h1 << $urandom_range(0, 31));
        default: ins = $urandom;
      endcase
      outs_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) != 0);
      idle(1);
    end
    ins_valid = 0;
    rst = 1;
    outs_ready = 1;
    idle(4);
    check("drain_empty", int'(outs_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
